// File: rtl/acs_select_skid.sv
// acs_select_skid
//   Registered add-compare-select node with a 2-entry skid buffer.
//   Each accepted input beat computes c0 = pm0 + bm0 and c1 = pm1 + bm1,
//   saturates both candidates to the path-metric range, keeps the smaller
//   one (ties choose predecessor 0) and optionally subtracts norm_sub,
//   flooring at zero. The word {pm, dec, sat} is queued in a main register
//   (which drives the outputs) backed by one skid register.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   input handshake (in_ready is registered)
//   pm0, pm1         predecessor path metrics (unsigned, PM_W bits)
//   bm0, bm1         branch metrics (unsigned, BM_W bits)
//   norm_sub         normalisation amount, sampled with the beat
//   out_valid/ready  output handshake (out_valid is a register decode)
//   pm_out           selected, normalised path metric
//   dec_out          0 = predecessor 0 chosen, 1 = predecessor 1 chosen
//   sat_out          a candidate saturated in this beat
//   state_dbg        buffer FSM state (0 EMPTY, 1 ONE, 2 FULL)
//
// Handshake: a beat moves when valid and ready are both high on a rising
// clk edge; a source holds valid and data stable until then. in_ready and
// out_valid come only from registers, so neither depends on the other
// combinationally.
module acs_select_skid #(
  parameter int PM_W    = 3,
  parameter int BM_W    = 2,
  parameter int NORM_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  input  logic [PM_W-1:0] norm_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PM_W-1:0] pm_out,
  output logic            dec_out,
  output logic            sat_out,
  output logic [1:0]      state_dbg
);

  localparam int WORD_W = PM_W + 2;
  localparam logic [PM_W-1:0] PM_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // ---------------- datapath (combinational on the input beat) ----------
  logic [PM_W:0]     c0_w, c1_w;
  logic [PM_W-1:0]   c0_cl, c1_cl, sel, pm_n;
  logic              dec_n, sat_n;
  logic [WORD_W-1:0] word_in;

  always_comb begin
    // One extra bit so the carry out of the add shows the overflow.
    c0_w  = {1'b0, pm0} + {{(PM_W + 1 - BM_W){1'b0}}, bm0};
    c1_w  = {1'b0, pm1} + {{(PM_W + 1 - BM_W){1'b0}}, bm1};
    c0_cl = c0_w[PM_W] ? PM_MAX : c0_w[PM_W-1:0];
    c1_cl = c1_w[PM_W] ? PM_MAX : c1_w[PM_W-1:0];
    sat_n = c0_w[PM_W] | c1_w[PM_W];
    // Compare the clamped values: two saturated candidates are a tie.
    dec_n = (c1_cl < c0_cl);
    sel   = dec_n ? c1_cl : c0_cl;
    pm_n  = sel;
    if (NORM_EN != 0) begin
      pm_n = (sel >= norm_sub) ? (sel - norm_sub) : '0;
    end
    word_in = {pm_n, dec_n, sat_n};
  end

  // ---------------- skid buffer FSM ----------------
  state_t            state_q, state_d;
  logic [WORD_W-1:0] m_q, m_d;
  logic [WORD_W-1:0] s_q, s_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          m_d     = word_in;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          m_d = word_in;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          s_d     = word_in;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready is a flop loaded from the next state, never from out_ready.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      s_q        <= s_d;
    end
  end

  // Outputs hold the last delivered word while the buffer is empty.
  assign pm_out    = m_q[WORD_W-1:2];
  assign dec_out   = m_q[1];
  assign sat_out   = m_q[0];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_acs_select_skid.sv
module tb_acs_select_skid;

  localparam int PM_W = 3;
  localparam int BM_W = 2;
  localparam int W    = PM_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [PM_W-1:0] pm0 = '0, pm1 = '0, norm_sub = '0;
  logic [BM_W-1:0] bm0 = '0, bm1 = '0;

  logic            in_ready, out_valid, dec_out, sat_out;
  logic [PM_W-1:0] pm_out;
  logic [1:0]      state_dbg;

  logic            in_ready_nn, out_valid_nn, dec_nn, sat_nn;
  logic [PM_W-1:0] pm_nn;
  logic [1:0]      state_nn;

  acs_select_skid #(.PM_W(PM_W), .BM_W(BM_W), .NORM_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pm0(pm0), .pm1(pm1), .bm0(bm0), .bm1(bm1), .norm_sub(norm_sub),
    .out_valid(out_valid), .out_ready(out_ready), .pm_out(pm_out),
    .dec_out(dec_out), .sat_out(sat_out), .state_dbg(state_dbg)
  );

  // Same stimulus with normalisation disabled.
  acs_select_skid #(.PM_W(PM_W), .BM_W(BM_W), .NORM_EN(0)) dut_nn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nn),
    .pm0(pm0), .pm1(pm1), .bm0(bm0), .bm1(bm1), .norm_sub(norm_sub),
    .out_valid(out_valid_nn), .out_ready(out_ready), .pm_out(pm_nn),
    .dec_out(dec_nn), .sat_out(sat_nn), .state_dbg(state_nn)
  );

  logic [W-1:0] word;
  assign word = {pm_out, dec_out, sat_out};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  bit rand_rdy = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int a0, input int b0, input int a1,
                                         input int b1, input int nrm, input bit norm_en);
    int c0, c1, sel, pm;
    bit sat, dec;
    c0  = a0 + b0;
    c1  = a1 + b1;
    sat = (c0 > 7) || (c1 > 7);
    if (c0 > 7) c0 = 7;
    if (c1 > 7) c1 = 7;
    dec = (c1 < c0);
    sel = dec ? c1 : c0;
    pm  = sel;
    if (norm_en) pm = (sel >= nrm) ? sel - nrm : 0;
    model = {pm[2:0], dec, sat};
  endfunction

  // Inputs change only at posedge+1, so at negedge the handshake signals
  // show exactly what the next rising edge will see.
  logic [W-1:0] held_w = '0;
  bit           held_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold", {27'd0, word}, {27'd0, held_w});
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(pm0, bm0, pm1, bm1, norm_sub, 1'b1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 32'd1);
        else begin
          check("sb_word", {27'd0, word}, {27'd0, exp_q.pop_front()});
          n_pops++;
        end
      end
      held_v = out_valid && !out_ready;
      held_w = word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat(input int a0, input int b0, input int a1, input int b1, input int nrm);
    pm0 = a0[PM_W-1:0]; bm0 = b0[BM_W-1:0];
    pm1 = a1[PM_W-1:0]; bm1 = b1[BM_W-1:0];
    norm_sub = nrm[PM_W-1:0];
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else cyc();
    end
    if (!done) check("accept_timeout", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input int a0, input int b0, input int a1, input int b1, input int nrm);
    drive_beat(a0, b0, a1, b1, nrm);
    wait_accept();
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  int pops0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_word", {27'd0, word}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;

    // Basic beat: 1-cycle latency.
    out_ready = 1'b1;
    send_beat(2, 1, 3, 1, 0);
    @(negedge clk);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_word", {27'd0, word}, {27'd0, 5'b011_0_0});
    wait_drain();

    // Both candidates saturate: tie keeps predecessor 0.
    send_beat(6, 3, 7, 2, 0);
    @(negedge clk);
    check("t2_word", {27'd0, word}, {27'd0, 5'b111_0_1});
    wait_drain();

    // Normalisation floors at zero; the NORM_EN=0 instance keeps 2.
    send_beat(5, 2, 1, 1, 4);
    @(negedge clk);
    check("t3_word", {27'd0, word}, {27'd0, 5'b000_1_0});
    check("t3_nn_pm", {29'd0, pm_nn}, 32'd2);
    check("t3_nn_dec", {31'd0, dec_nn}, 32'd1);
    wait_drain();

    // Stall: two beats captured, third held off, then all four flow out.
    pops0 = n_pops;
    out_ready = 1'b0;
    send_beat(1, 1, 2, 2, 0);
    send_beat(4, 0, 3, 0, 1);
    @(negedge clk);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_state", {30'd0, state_dbg}, 32'd2);
    @(posedge clk); #1;
    drive_beat(7, 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_blocked", {31'd0, in_ready}, 32'd0);
      check("t4_head", {27'd0, word}, {27'd0, model(1, 1, 2, 2, 0, 1'b1)});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    send_beat(3, 3, 3, 3, 2);
    wait_drain();
    check("t4_count", n_pops - pops0, 32'd4);

    // Random valid/ready traffic.
    pops0 = n_pops;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      send_beat($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 7));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("t5_count", n_pops - pops0, 32'd1000);

    // Reset while FULL, with a beat offered during the reset cycle.
    out_ready = 1'b0;
    send_beat(0, 1, 0, 2, 0);
    send_beat(6, 1, 5, 0, 0);
    @(negedge clk);
    check("t6_full", {30'd0, state_dbg}, 32'd2);
    @(posedge clk); #1;
    drive_beat(2, 2, 2, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_word", {27'd0, word}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_beats", {31'd0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
